ad79x8_sequencer: RTL and testbench
===================================

# ad79x8_sequencer

Parametrised SPI master and channel sequencer for the AD7908/AD7918/AD7928 ADC family. It generates SCLK and CS, writes a control word in every frame, and walks a programmable channel mask in one-shot or continuous sweeps. Each result is tagged with the channel address the ADC returns and pushed into an internal result FIFO, which the consumer drains over a valid/ready stream. It replaces the single-frame bus interface in the acquisition path.

## Interface
- CLK_DIV, 10: clk cycles per SCLK period; even, ≥4; H = CLK_DIV/2.
- RESOLUTION, 12: ADC data bits (8, 10 or 12).
- QUIET_CYCLES, 4: clk cycles CS stays high between frames; ≥1.
- FIFO_DEPTH, 8: result FIFO entries; power of 2, ≥2.
- clk  in  1  system clock; everything is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; ignored while busy.
- continuous  in  1  when 1, repeat sweeps; sampled at the end of each sweep.
- channel_mask  in  8  enabled channels; captured on start; 0 makes start a no-op.
- range_sel, coding  in  1 each  written to control word bits 5 and 4.
- sclk  out  1  serial clock; idles high.
- cs_n  out  1  chip select, active low.
- serial_out  out  1  to ADC DIN.
- serial_in  in  1  from ADC DOUT.
- busy  out  1  high from the start acceptance until the final frame's quiet period ends.
- res_valid, res_ready  out/in  1  result stream handshake.
- res_data  out  RESOLUTION  conversion result.
- res_channel  out  3  channel tag.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Reset values: sclk=1, cs_n=1, serial_out=0, busy=0, res_valid=0, overflow=0, fifo_level=0, FSM=IDLE. The FIFO is emptied.
- FSM states: IDLE → FRAME → QUIET → FRAME … → IDLE.
- IDLE: when start=1 and channel_mask≠0, capture the mask, clear overflow, set busy, and go to FRAME. The first frame of the sweep is the prime frame.
- Control word written each frame: bit 15 WRITE=1, bit 14 SEQ=0, bits 12:10 = address of the next enabled channel, bits 9:8 PM=11, bit 7 SHADOW=0, bit 5 = range_sel, bit 4 = coding, all other bits 0.
  - In the prime frame, the address is the lowest enabled channel.
  - In later frames, the address is the next enabled channel in ascending order. In the sweep's last frame it wraps to the lowest enabled channel.
- Sweep length is popcount(mask)+1 frames. The prime frame's DOUT is discarded. Every other frame yields exactly one result.
- DOUT word layout: bit 15 = 0, bits 14:12 = address, bits 11:0 = data MSB-first. res_data is bits 11:(12-RESOLUTION). res_channel is bits 14:12.
- End of sweep: if continuous=1, the next frame is a new sweep without a prime frame, and busy stays high. Otherwise go to IDLE.
- FIFO: push at the end of a result frame. If full, drop the result and set overflow. Pop when res_valid & res_ready. Push and pop in the same cycle are allowed; level is unchanged and no overflow is raised when a pop frees the slot.
- reset_n=0 mid-frame aborts immediately. cs_n and sclk go high on the next edge. No partial result is pushed.

## Timing
- Frame cycle 0 (FRAME entry): cs_n falls, sclk=1, serial_out = control bit 15.
- Falling edge k (k=1..16) at cycle (2k−1)·H: sclk→0. The ADC samples DIN here.
- Rising edge k at cycle 2k·H: sclk→1, serial_in is sampled as DOUT bit 16−k, and serial_out advances to control bit 15−k (0 after k=16).
- cs_n rises at cycle 33·H. QUIET then holds cs_n high for QUIET_CYCLES cycles.
- Frame period is 33·H + QUIET_CYCLES cycles.
- Result latency: res_valid rises on the cycle after cs_n rises, if the FIFO was empty.
- busy falls on the last QUIET cycle, so a start on the following cycle is accepted.
- res_data and res_channel are held stable while res_valid=1 and res_ready=0.

## Test plan
- Defaults with CLK_DIV=4, mask=8'h05, one-shot, ADC model returning 0x1ABC for channel 1 and 0x0123 for others:
  - Expect 3 frames, each with cs_n low for 66 cycles and 16 SCLK falls.
  - Expect DIN words 0x8330, 0x8B30, 0x8330.
  - Expect results (ch0, 0x123) then (ch2, 0x123).
  - busy is low after 3·70 cycles.
- RESOLUTION=8, mask=8'h80, DOUT=0x7ABC → res_data=0xAB, res_channel=7.
- continuous=1, mask=8'h03, held for 2 sweeps then dropped → 5 frames and 4 results in order ch0, ch1, ch0, ch1.
- FIFO_DEPTH=2 with res_ready=0 over a 4-channel sweep → fifo_level saturates at 2, overflow=1, and the first two results are retained. A new start clears overflow.
- reset_n=0 at sclk fall 7 of frame 2 → cs_n=1 and sclk=1 on the next edge, busy=0, fifo_level=0.
- start with mask=0, and start while busy → no frame is issued and busy is unaffected.

Source files
------------

// File: rtl/ad79x8_sequencer.sv
// ad79x8_sequencer: SPI master and channel sequencer for AD7908/AD7918/AD7928 with a result FIFO
// ports: clk, reset_n (sync, active low); start/continuous/channel_mask/range_sel/coding launch and shape a sweep;
// sclk/cs_n/serial_out/serial_in form the ADC link; res_valid/res_ready/res_data/res_channel drain results;
// busy, overflow and fifo_level report status.
module ad79x8_sequencer #(
  parameter int CLK_DIV      = 10,
  parameter int RESOLUTION   = 12,
  parameter int QUIET_CYCLES = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [7:0]                    channel_mask,
  input  logic                          range_sel,
  input  logic                          coding,
  output logic                          sclk,
  output logic                          cs_n,
  output logic                          serial_out,
  input  logic                          serial_in,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [RESOLUTION-1:0]         res_data,
  output logic [2:0]                    res_channel,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int H  = CLK_DIV / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(H + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FRAME, QUIET} state_t;
  state_t state, state_n;
  logic [HW-1:0] hc, hc_n;
  logic [5:0] ph, ph_n;
  logic [QW-1:0] qc, qc_n;
  logic [7:0] mask_q;
  logic [2:0] addr, next_addr, lowest;
  logic prime, again, last, done;
  logic tick, rise, frame_end, quiet_end, accept, enter, push, pop, full, push_ok;
  logic [15:0] ctrl, tx;
  logic [14:0] rx;
  logic [AW-1:0] wp, rp;
  logic [RESOLUTION+2:0] mem [FIFO_DEPTH];
  // first enabled channel strictly after c in ascending order, wrapping; c itself if it is the only one
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r, k;
    r = c;
    for (int i = 8; i >= 1; i--) begin
      k = c + 3'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction
  // ph counts half SCLK periods within a frame: odd phases are SCLK low, phase 32 is the tail before cs_n rises
  always_comb begin
    tick = hc == HW'(H - 1);
    rise = state == FRAME && tick && ph[0];
    frame_end = state == FRAME && tick && ph == 6'd32;
    quiet_end = state == QUIET && qc == QW'(QUIET_CYCLES - 1);
    accept = state == IDLE && start && |channel_mask;
    lowest = next_ch(mask_q, 3'd7);
    last = !prime && addr == lowest;
    done = last && !again;
    next_addr = state == IDLE ? next_ch(channel_mask, 3'd7) : next_ch(mask_q, addr);
    ctrl = {3'b100, next_addr, 2'b11, 2'b00, range_sel, coding, 4'b0000};
    state_n = state;
    hc_n = '0;
    ph_n = '0;
    qc_n = '0;
    case (state)
      IDLE: state_n = accept ? FRAME : IDLE;
      FRAME: begin
        state_n = frame_end ? QUIET : FRAME;
        hc_n = tick ? '0 : hc + 1'b1;
        ph_n = ph + 6'(tick);
      end
      QUIET: begin
        state_n = quiet_end ? (done ? IDLE : FRAME) : QUIET;
        qc_n = qc + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    enter = state_n == FRAME && state != FRAME;
    // a frame's result is pushed one cycle after cs_n rises; the prime frame carries no result
    push = state == QUIET && qc == '0 && !prime;
    pop = res_valid && res_ready;
    full = fifo_level == LW'(FIFO_DEPTH);
    push_ok = push && (!full || pop);
  end
  assign busy = state == FRAME || (state == QUIET && !(quiet_end && done));
  assign serial_out = tx[15];
  assign res_valid = fifo_level != '0;
  assign {res_channel, res_data} = mem[rp];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      hc <= '0;
      ph <= '0;
      qc <= '0;
      sclk <= 1'b1;
      cs_n <= 1'b1;
      tx <= '0;
      mask_q <= '0;
      addr <= '0;
      prime <= 1'b0;
      again <= 1'b0;
      overflow <= 1'b0;
      fifo_level <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_n;
      hc <= hc_n;
      ph <= ph_n;
      qc <= qc_n;
      sclk <= !(state_n == FRAME && ph_n[0]);
      cs_n <= state_n != FRAME;
      tx <= enter ? ctrl : rise ? {tx[14:0], 1'b0} : tx;
      if (enter) begin
        addr <= next_addr;
        prime <= state == IDLE;
      end
      if (accept) mask_q <= channel_mask;
      if (frame_end) again <= continuous;
      overflow <= !accept && (overflow || (push && !push_ok));
      fifo_level <= fifo_level + LW'(push_ok) - LW'(pop);
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rise) rx <= {rx[13:0], serial_in};
    if (push_ok) mem[wp] <= {rx[14:12], rx[11 -: RESOLUTION]};
  end
endmodule

// File: tb/tb_ad79x8_sequencer.sv
// tb_ad79x8_sequencer: directed bench for ad79x8_sequencer with behavioural ADC models
module tb_ad79x8_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic start_a = 1'b0, start_b = 1'b0, continuous = 1'b0, range_sel = 1'b1, coding = 1'b1;
  logic res_ready_a = 1'b0, res_ready_b = 1'b0;
  logic [7:0] channel_mask = 8'h00;
  logic si_a = 1'b0, si_b = 1'b0;
  logic sclk_a, cs_n_a, so_a, busy_a, valid_a, ovf_a;
  logic [11:0] data_a;
  logic [2:0] ch_a;
  logic [3:0] lvl_a;
  logic sclk_b, cs_n_b, so_b, busy_b, valid_b, ovf_b;
  logic [7:0] data_b;
  logic [2:0] ch_b;
  logic [1:0] lvl_b;
  int checks = 0, fails = 0;

  ad79x8_sequencer #(.CLK_DIV(4), .RESOLUTION(12), .QUIET_CYCLES(4), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .continuous(continuous), .channel_mask(channel_mask),
    .range_sel(range_sel), .coding(coding), .sclk(sclk_a), .cs_n(cs_n_a), .serial_out(so_a),
    .serial_in(si_a), .busy(busy_a), .res_valid(valid_a), .res_ready(res_ready_a), .res_data(data_a),
    .res_channel(ch_a), .overflow(ovf_a), .fifo_level(lvl_a));

  ad79x8_sequencer #(.CLK_DIV(4), .RESOLUTION(8), .QUIET_CYCLES(4), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .continuous(continuous), .channel_mask(channel_mask),
    .range_sel(range_sel), .coding(coding), .sclk(sclk_b), .cs_n(cs_n_b), .serial_out(so_b),
    .serial_in(si_b), .busy(busy_b), .res_valid(valid_b), .res_ready(res_ready_b), .res_data(data_b),
    .res_channel(ch_b), .overflow(ovf_b), .fifo_level(lvl_b));

  // ADC returns the conversion for the address written in the previous frame
  function automatic logic [11:0] dat(input logic [2:0] c);
    return (c == 3'd1 || c == 3'd7) ? 12'hABC : 12'h123;
  endfunction

  logic [15:0] word_a, din_a = '0, word_b, din_b = '0;
  logic [2:0] last_a = '0, last_b = '0;
  int falls_a = 0, frames_a = 0, falls_b = 0, frames_b = 0;
  bit inf_a = 1'b0, inf_b = 1'b0;
  longint t_a, t_b;
  logic [15:0] dq_a[$];
  int fq_a[$], lq_a[$];

  always @(negedge cs_n_a) begin
    inf_a = 1'b1; t_a = $time; falls_a = 0;
    word_a = {1'b0, last_a, dat(last_a)}; si_a = word_a[15];
  end
  always @(negedge sclk_a) if (inf_a) begin
    falls_a++; din_a = {din_a[14:0], so_a};
    if (falls_a <= 16) si_a = word_a[16-falls_a];
  end
  always @(posedge cs_n_a) if (inf_a) begin
    inf_a = 1'b0; frames_a++;
    dq_a.push_back(din_a); fq_a.push_back(falls_a); lq_a.push_back(int'(($time - t_a) / 10));
    if (falls_a == 16) last_a = din_a[12:10];
  end

  always @(negedge cs_n_b) begin
    inf_b = 1'b1; t_b = $time; falls_b = 0;
    word_b = {1'b0, last_b, dat(last_b)}; si_b = word_b[15];
  end
  always @(negedge sclk_b) if (inf_b) begin
    falls_b++; din_b = {din_b[14:0], so_b};
    if (falls_b <= 16) si_b = word_b[16-falls_b];
  end
  always @(posedge cs_n_b) if (inf_b) begin
    inf_b = 1'b0; frames_b++;
    if (falls_b == 16) last_b = din_b[12:10];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
  endtask
  task automatic pulse_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
  endtask

  task automatic pop_a(input logic [2:0] ec, input logic [11:0] ed);
    chk("a_pop_valid", valid_a, 1); chk("a_pop_ch", ch_a, ec); chk("a_pop_data", data_a, ed);
    res_ready_a = 1'b1; @(negedge clk); res_ready_a = 1'b0;
  endtask
  task automatic pop_b(input logic [2:0] ec, input logic [7:0] ed);
    chk("b_pop_valid", valid_b, 1); chk("b_pop_ch", ch_b, ec); chk("b_pop_data", data_b, ed);
    res_ready_b = 1'b1; @(negedge clk); res_ready_b = 1'b0;
  endtask

  initial begin
    int n, vfirst;
    logic [15:0] exp1 [3];
    exp1 = '{16'h8330, 16'h8B30, 16'h8330};
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk_a, 1); chk("rst_cs_n", cs_n_a, 1); chk("rst_sout", so_a, 0);
    chk("rst_busy", busy_a, 0); chk("rst_valid", valid_a, 0); chk("rst_ovf", ovf_a, 0);
    chk("rst_level", lvl_a, 0); chk("rst_b_level", lvl_b, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // one-shot sweep over channels 0 and 2
    channel_mask = 8'h05; n = frames_a; vfirst = -1;
    pulse_a;
    chk("t1_cs_n_c0", cs_n_a, 0); chk("t1_sclk_c0", sclk_a, 1); chk("t1_sout_c0", so_a, 1); chk("t1_busy_c0", busy_a, 1);
    for (int c = 1; c <= 209; c++) begin
      @(negedge clk);
      if (valid_a && vfirst < 0) vfirst = c;
      if (c == 2) chk("t1_sclk_c2", sclk_a, 0);
      if (c == 208) chk("t1_busy_c208", busy_a, 1);
    end
    chk("t1_busy_c209", busy_a, 0);
    chk("t1_valid_latency", vfirst, 137);
    chk("t1_frames", frames_a - n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_din", dq_a[n+i], exp1[i]);
      chk("t1_falls", fq_a[n+i], 16);
      chk("t1_cs_low", lq_a[n+i], 66);
    end
    chk("t1_level", lvl_a, 2);
    pop_a(3'd0, 12'h123);
    pop_a(3'd2, 12'h123);
    chk("t1_empty_valid", valid_a, 0); chk("t1_empty_level", lvl_a, 0);

    // 8-bit resolution, channel 7 only
    channel_mask = 8'h80;
    pulse_b;
    repeat (145) @(negedge clk);
    chk("t2_busy", busy_b, 0); chk("t2_level", lvl_b, 1);
    pop_b(3'd7, 8'hAB);
    chk("t2_level_after", lvl_b, 0);

    // depth-2 FIFO overflow over a 4-channel sweep
    channel_mask = 8'h0F;
    pulse_b;
    repeat (355) @(negedge clk);
    chk("t4_busy", busy_b, 0); chk("t4_level", lvl_b, 2); chk("t4_ovf", ovf_b, 1);
    pop_b(3'd0, 8'h12);
    pop_b(3'd1, 8'hAB);
    chk("t4_level_drained", lvl_b, 0); chk("t4_ovf_sticky", ovf_b, 1);
    channel_mask = 8'h01;
    pulse_b;
    chk("t4_ovf_cleared", ovf_b, 0);
    repeat (145) @(negedge clk);
    chk("t4_level_new", lvl_b, 1); chk("t4_ovf_new", ovf_b, 0);
    pop_b(3'd0, 8'h12);

    // continuous sweeps over channels 0 and 1, dropped during the second sweep
    channel_mask = 8'h03; continuous = 1'b1; n = frames_a;
    pulse_a;
    for (int c = 1; c <= 349; c++) begin
      @(negedge clk);
      if (c == 209) chk("t3_busy_c209", busy_a, 1);
      if (c == 230) continuous = 1'b0;
      if (c == 348) chk("t3_busy_c348", busy_a, 1);
    end
    chk("t3_busy_c349", busy_a, 0);
    chk("t3_frames", frames_a - n, 5);
    chk("t3_level", lvl_a, 4);
    pop_a(3'd0, 12'h123);
    pop_a(3'd1, 12'hABC);
    pop_a(3'd0, 12'h123);
    repeat (5) @(negedge clk);
    chk("t3_hold_ch", ch_a, 1); chk("t3_hold_data", data_a, 12'hABC); chk("t3_hold_level", lvl_a, 1);

    // reset at SCLK fall 7 of frame 2
    channel_mask = 8'h05; n = frames_a;
    pulse_a;
    repeat (96) @(negedge clk);
    chk("t5_sclk_low", sclk_a, 0); chk("t5_cs_low", cs_n_a, 0);
    chk("t5_frame_no", frames_a - n, 1); chk("t5_falls", falls_a, 7);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_cs_n", cs_n_a, 1); chk("t5_sclk", sclk_a, 1); chk("t5_busy", busy_a, 0);
    chk("t5_level", lvl_a, 0); chk("t5_valid", valid_a, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // start with empty mask, then start while busy
    channel_mask = 8'h00; n = frames_a;
    pulse_a;
    chk("t6_busy_mask0", busy_a, 0);
    repeat (10) @(negedge clk);
    chk("t6_cs_mask0", cs_n_a, 1); chk("t6_frames_mask0", frames_a - n, 0);
    channel_mask = 8'h05; n = frames_a;
    pulse_a;
    for (int c = 1; c <= 209; c++) begin
      @(negedge clk);
      if (c == 20) begin channel_mask = 8'h0F; start_a = 1'b1; end
      if (c == 21) start_a = 1'b0;
      if (c == 208) chk("t6_busy_c208", busy_a, 1);
    end
    chk("t6_busy_c209", busy_a, 0);
    chk("t6_frames", frames_a - n, 3);
    chk("t6_din2", dq_a[n+1], 16'h8B30);
    chk("t6_din3", dq_a[n+2], 16'h8330);
    chk("t6_level", lvl_a, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
